// File: rtl/fetch_pair_ctrl.sv
// Dual-issue fetch sequencer: drives the imem PC pair, registers the returned words
// and hands them to decode. Build with FETCH_PERF_CNT_EN for stall/issue counters.
module fetch_pair_ctrl #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32,
  parameter int PC_STEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr1,
  output logic [PC_W-1:0]    imem_addr2,
  input  logic [INSTR_W-1:0] imem_data1,
  input  logic [INSTR_W-1:0] imem_data2,
  output logic               out_valid,
  output logic               out_valid2,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr1_o,
  output logic [INSTR_W-1:0] instr2_o,
  output logic [PC_W-1:0]    pc1_o,
  output logic [PC_W-1:0]    pc2_o,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               busy,
  output logic               done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_stall_cnt,
  output logic [15:0]        perf_issue_cnt
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for start, outputs at reset values
  // S_FETCH | loading a pair whenever the output register is free
  // S_DRAIN | end of program seen, waiting for the last pair to leave
  // S_DONE  | halted until redirect or reset
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [PC_W-1:0] STEP1      = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] STEP2      = PC_W'(2 * PC_STEP);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;
  logic               valid2_q, valid2_d;
  logic [INSTR_W-1:0] instr1_q, instr1_d;
  logic [INSTR_W-1:0] instr2_q, instr2_d;
  logic [PC_W-1:0]    pc1_q, pc1_d;
  logic [PC_W-1:0]    pc2_q, pc2_d;
  logic               load;
  logic               halt;

  assign load = (state_q == S_FETCH) && (!valid_q || out_ready) && !redirect;
  assign halt = (imem_data1 == '0) || (imem_data2 == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      valid2_q <= 1'b0;
      instr1_q <= '0;
      instr2_q <= '0;
      pc1_q    <= '0;
      pc2_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      valid2_q <= valid2_d;
      instr1_q <= instr1_d;
      instr2_q <= instr2_d;
      pc1_q    <= pc1_d;
      pc2_q    <= pc2_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    valid2_d = valid2_q;
    instr1_d = instr1_q;
    instr2_d = instr2_q;
    pc1_d    = pc1_q;
    pc2_d    = pc2_q;
    // Redirect outranks load, consume and halt; stale data is left for valid to mask.
    if (redirect && (state_q != S_IDLE)) begin
      state_d  = S_FETCH;
      pc_d     = redirect_pc & ALIGN_MASK;
      valid_d  = 1'b0;
      valid2_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            pc_d    = '0;
          end
        end
        S_FETCH: begin
          if (load) begin
            instr1_d = imem_data1;
            instr2_d = imem_data2;
            pc1_d    = pc_q;
            pc2_d    = pc_q + STEP1;
            valid_d  = (imem_data1 != '0);
            valid2_d = (imem_data1 != '0) && (imem_data2 != '0);
            pc_d     = pc_q + STEP2;
            if (halt) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!valid_q) begin
            state_d = S_DONE;
          end else if (out_ready) begin
            valid_d  = 1'b0;
            valid2_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr1 = pc_q;
  assign imem_addr2 = pc_q + STEP1;
  assign out_valid  = valid_q;
  assign out_valid2 = valid2_q;
  assign instr1_o   = instr1_q;
  assign instr2_o   = instr2_q;
  assign pc1_o      = pc1_q;
  assign pc2_o      = pc2_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] issue_cnt_q;
  logic [16:0] issue_sum;

  assign issue_sum = {1'b0, issue_cnt_q} + 17'(valid_q) + 17'(valid2_q);

  // Counters survive redirect; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      if (valid_q && !out_ready && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (valid_q && out_ready)
        issue_cnt_q <= issue_sum[16] ? 16'hFFFF : issue_sum[15:0];
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pair_ctrl.sv
// Self-checking bench for fetch_pair_ctrl: predicted pairs are queued per scenario
// and compared as decode consumes them.
module tb_fetch_pair_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, out_ready, redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr1, imem_addr2, pc1_o, pc2_o;
  logic [31:0] imem_data1, imem_data2, instr1_o, instr2_o;
  logic        out_valid, out_valid2, busy, done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_stall_cnt, perf_issue_cnt;
`endif

  logic [31:0] mem [0:63];
  assign imem_data1 = mem[imem_addr1[7:2]];
  assign imem_data2 = mem[imem_addr2[7:2]];

  always #5 clk = ~clk;

  fetch_pair_ctrl #(.PC_W(8), .INSTR_W(32), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr1(imem_addr1), .imem_addr2(imem_addr2),
    .imem_data1(imem_data1), .imem_data2(imem_data2),
    .out_valid(out_valid), .out_valid2(out_valid2), .out_ready(out_ready),
    .instr1_o(instr1_o), .instr2_o(instr2_o), .pc1_o(pc1_o), .pc2_o(pc2_o),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy), .done(done)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_issue_cnt(perf_issue_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0]  pc1;
    logic [7:0]  pc2;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        v2;
  } pair_t;

  pair_t sb[$];
  int vectors = 0;
  int errors  = 0;

  task automatic push_pair(input logic [7:0] p);
    pair_t e;
    logic [7:0] p2;
    p2   = p + 8'd4;
    e.pc1 = p;
    e.pc2 = p2;
    e.i1  = mem[p[7:2]];
    e.i2  = mem[p2[7:2]];
    e.v2  = (e.i1 != 0) && (e.i2 != 0);
    sb.push_back(e);
  endtask

  // Scoreboard: every handshake must match the oldest predicted pair.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !redirect) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc1=%h none expected", pc1_o);
      end else begin
        pair_t e;
        e = sb.pop_front();
        if ({pc1_o, pc2_o, instr1_o, instr2_o, out_valid2} !== {e.pc1, e.pc2, e.i1, e.i2, e.v2}) begin
          errors++;
          $display("FAIL sb_pair got pc=%h/%h i=%h/%h v2=%b required pc=%h/%h i=%h/%h v2=%b",
                   pc1_o, pc2_o, instr1_o, instr2_o, out_valid2, e.pc1, e.pc2, e.i1, e.i2, e.v2);
        end
      end
    end
    if (rst_n) begin
      vectors++;
      if (out_valid2 && !out_valid) begin
        errors++;
        $display("FAIL v2_implies_v got v=%b v2=%b required v2 only with v", out_valid, out_valid2);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; redirect = 1'b0; out_ready = 1'b0; redirect_pc = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; redirect = 1'b1; out_ready = 1'b1; redirect_pc = 8'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({out_valid, out_valid2, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got v=%b v2=%b busy=%b done=%b required 0000", out_valid, out_valid2, busy, done);
    end
    vectors++;
    if ({instr1_o, instr2_o, pc1_o, pc2_o, imem_addr1} !== '0) begin
      errors++;
      $display("FAIL reset_data got i=%h/%h pc=%h/%h addr=%h required all 0", instr1_o, instr2_o, pc1_o, pc2_o, imem_addr1);
    end
    @(posedge clk); #1 rst_n = 1'b1; start = 1'b0;
    // redirect is still high: it must be ignored in IDLE
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, out_valid, imem_addr1} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL idle_redirect got busy=%b v=%b addr=%h required 0 0 00", busy, out_valid, imem_addr1);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    for (int k = 0; k < 5; k++) push_pair(8'(k * 8));
    out_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    vectors++;
    if ({busy, out_valid, imem_addr1, imem_addr2} !== {1'b1, 1'b0, 8'h00, 8'h04}) begin
      errors++;
      $display("FAIL fetch_entry got busy=%b v=%b addr=%h/%h required 1 0 00/04", busy, out_valid, imem_addr1, imem_addr2);
    end
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin @(negedge clk); #1; end
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL seq_drain got %0d pending required 0", sb.size());
    end
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    pulse_start();
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, pc1_o, pc2_o, instr1_o, imem_addr1} !== {1'b1, 8'h00, 8'h04, mem[0], 8'h08}) begin
        errors++;
        $display("FAIL stall_hold cyc%0d got v=%b pc=%h/%h i1=%h addr=%h required 1 00/04 %h 08",
                 c, out_valid, pc1_o, pc2_o, instr1_o, imem_addr1, mem[0]);
      end
    end
    push_pair(8'h00);
    push_pair(8'h08);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin @(negedge clk); #1; end
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stall_drain got %0d pending required 0", sb.size());
    end
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_redirect_stall();
    do_reset();
    pulse_start();
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL redir_pre got v=%b required 1", out_valid);
    end
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 8'h23;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid, out_valid2, imem_addr1, busy} !== {1'b0, 1'b0, 8'h20, 1'b1}) begin
      errors++;
      $display("FAIL redir_flush got v=%b v2=%b addr=%h busy=%b required 0 0 20 1", out_valid, out_valid2, imem_addr1, busy);
    end
    push_pair(8'h20);
    push_pair(8'h28);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin @(negedge clk); #1; end
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL redir_drain got %0d pending required 0", sb.size());
    end
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_halt_done();
    do_reset();
    mem[5] = 32'h0;
    push_pair(8'h00);
    push_pair(8'h08);
    push_pair(8'h10);
    out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin @(negedge clk); #1; end
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL halt_drain got %0d pending required 0", sb.size());
    end
    @(negedge clk);
    vectors++;
    if ({busy, done, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL drain_state got busy=%b done=%b v=%b required 1 0 0", busy, done, out_valid);
    end
    @(negedge clk);
    vectors++;
    if ({busy, done, imem_addr1} !== {1'b0, 1'b1, 8'h18}) begin
      errors++;
      $display("FAIL done_state got busy=%b done=%b addr=%h required 0 1 18", busy, done, imem_addr1);
    end
    pulse_start();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({done, out_valid, imem_addr1} !== {1'b1, 1'b0, 8'h18}) begin
        errors++;
        $display("FAIL done_start_ignored got done=%b v=%b addr=%h required 1 0 18", done, out_valid, imem_addr1);
      end
    end
    mem[5] = 32'hA000_0005;
    push_pair(8'h40);
    push_pair(8'h48);
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 8'h41;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, out_valid, imem_addr1} !== {1'b1, 1'b0, 1'b0, 8'h40}) begin
      errors++;
      $display("FAIL done_redirect got busy=%b done=%b v=%b addr=%h required 1 0 0 40", busy, done, out_valid, imem_addr1);
    end
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin @(negedge clk); #1; end
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL resume_drain got %0d pending required 0", sb.size());
    end
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] tgt [2];
    logic [7:0] base;
    tgt[0] = 8'hF8;
    tgt[1] = 8'hFE;
    do_reset();
    pulse_start();
    for (int t = 0; t < 2; t++) begin
      base = tgt[t] & 8'hFC;
      @(posedge clk); #1 redirect = 1'b1; redirect_pc = tgt[t]; out_ready = 1'b0;
      @(posedge clk); #1 redirect = 1'b0;
      sb.delete();
      push_pair(base);
      push_pair(base + 8'd8);
      push_pair(base + 8'd16);
      @(negedge clk);
      vectors++;
      if ({out_valid, imem_addr1, imem_addr2} !== {1'b0, base, base + 8'd4}) begin
        errors++;
        $display("FAIL wrap_entry got v=%b addr=%h/%h required 0 %h/%h", out_valid, imem_addr1, imem_addr2, base, base + 8'd4);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      for (int k = 0; k < 10 && sb.size() != 0; k++) begin @(negedge clk); #1; end
      vectors++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL wrap_drain got %0d pending required 0", sb.size());
      end
    end
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start();
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({out_valid, busy} !== 2'b11) begin
      errors++;
      $display("FAIL mid_pre got v=%b busy=%b required 1 1", out_valid, busy);
    end
    @(posedge clk); #1 rst_n = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({out_valid, out_valid2, busy, done, instr1_o, instr2_o, pc1_o, pc2_o, imem_addr1} !== '0) begin
      errors++;
      $display("FAIL mid_reset got v=%b v2=%b busy=%b done=%b i=%h/%h pc=%h/%h addr=%h required all 0",
               out_valid, out_valid2, busy, done, instr1_o, instr2_o, pc1_o, pc2_o, imem_addr1);
    end
    #1 rst_n = 1'b1; start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    test_reset();
    test_sequence();
    test_stall();
    test_redirect_stall();
    test_halt_done();
    test_wrap();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_pair_ctrl.md
Name: fetch_pair_ctrl

Overview:
- Sequences instruction fetch for the dual-issue front end. Generates the PC pair for instruction memory, captures the two returned words plus their PCs into an output pair register, and presents them to the decode stage with a valid/ready handshake.
- Handles downstream stall, end-of-program detection (all-zero instruction word) and PC redirect from branch resolution.
- Sits between instruction memory and decode. It replaces the level `start` gating with a real sequencer.

Parameters:
- PC_W, 8, PC width in bits; all PC arithmetic is modulo 2^PC_W
- INSTR_W, 32, instruction word width
- PC_STEP, 4, byte distance between consecutive instructions

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  begin fetching from PC 0; sampled only in IDLE
- imem_addr1  output  PC_W  address of slot-1 word (combinational = pc)
- imem_addr2  output  PC_W  address of slot-2 word (combinational = pc+PC_STEP)
- imem_data1  input  INSTR_W  word at imem_addr1, same-cycle (combinational memory)
- imem_data2  input  INSTR_W  word at imem_addr2, same-cycle
- out_valid  output  1  pair register holds a valid slot-1 instruction
- out_valid2  output  1  slot-2 instruction also valid
- out_ready  input  1  decode accepts pair this cycle
- instr1_o, instr2_o  output  INSTR_W  registered instruction words
- pc1_o, pc2_o  output  PC_W  registered PCs of the two slots
- redirect  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  PC_W  new fetch PC; bits [1:0] forced to 0
- busy  output  1  state is FETCH or DRAIN
- done  output  1  state is DONE

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE; pc=0.
  - out_valid=0, out_valid2=0; instr1_o, instr2_o, pc1_o, pc2_o = 0.
  - busy=0, done=0. Reset wins over every other input.
- States: IDLE, FETCH, DRAIN, DONE.
- Load condition: `load = (state==FETCH) && (!out_valid || out_ready) && !redirect`.
- IDLE:
  - start=1 goes to FETCH next cycle with pc=0.
  - Outputs stay at reset values.
- FETCH, on load:
  - instr1_o=imem_data1, instr2_o=imem_data2, pc1_o=pc, pc2_o=pc+PC_STEP.
  - out_valid = (imem_data1!=0).
  - out_valid2 = (imem_data1!=0 && imem_data2!=0).
  - pc <= pc+2*PC_STEP. Latency is 1 cycle from address to registered pair.
- FETCH, halt detection: if imem_data1==0 or imem_data2==0 on a load, go to DRAIN. No further PC advance.
- FETCH, stall (out_valid && !out_ready): pair register, pc and state hold unchanged.
- FETCH, handshake: a pair is consumed on any cycle with out_valid && out_ready. On the same edge it is replaced by the next load.
- DRAIN:
  - No loads. On out_valid && out_ready, out_valid and out_valid2 clear.
  - When out_valid==0 at a clock edge, go to DONE.
- DONE:
  - done=1; outputs hold out_valid=0.
  - start is ignored. Leaves only via redirect or reset.
- Redirect (any state except IDLE):
  - Next edge: out_valid=0, out_valid2=0, pc={redirect_pc[PC_W-1:2],2'b00}, state=FETCH.
  - Redirect has priority over load, consume and halt.
  - Data words and PCs in the pair register may keep stale values; consumers must qualify with valid.
- Wrap-around: pc, pc+PC_STEP and pc+2*PC_STEP wrap modulo 2^PC_W. For example, pc=0xFC gives pc2_o=0x00 and next pc=0x04.
- out_valid2=1 implies out_valid=1 at all times.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs `perf_stall_cnt` (16 bits) and `perf_issue_cnt` (16 bits), both reset to 0.
  - perf_stall_cnt increments each cycle with out_valid && !out_ready.
  - perf_issue_cnt adds out_valid+out_valid2 on each consume.
  - Both saturate at 0xFFFF and are not cleared by redirect.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then start=1, imem returns nonzero words, out_ready=1 → first pair one cycle after FETCH entry with pc1_o=0x00, pc2_o=0x04; next pairs 0x08/0x0C, 0x10/0x14.
- Hold out_ready=0 for 3 cycles with a valid pair present → instr/pc outputs and imem_addr1 unchanged for all 3 cycles. On out_ready=1 the next pair 0x08/0x0C loads.
- imem_data2=0 at pc=0x10 → pair has out_valid=1, out_valid2=0, pc1_o=0x10. After consume, state goes DRAIN→DONE, done=1, and imem_addr1 stops at 0x18.
- redirect=1 with redirect_pc=0x23 during a stall → next cycle out_valid=0, imem_addr1=0x20. The following pair is 0x20/0x24. Also assert redirect in DONE → fetch resumes.
- Redirect to 0xF8 → pairs 0xF8/0xFC, then 0x00/0x04 (wrap).
- rst_n=0 asserted mid-FETCH with out_valid=1 → next cycle all outputs 0, state IDLE. start pulsed in DONE (no redirect) → no change.
